rv32is_core: RTL and testbench
==============================

Name: rv32is_core

Overview:
- Single-cycle RV32I integer CPU core.
- Every instruction is fetched, decoded, executed and retired in one clock cycle.
- Connects to an external instruction memory and an external data memory.
- Exposes a debug word for bring-up benches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imemaddr  output  32  instruction address; equals current PC.
- imemdataout  input  32  instruction word at imemaddr; must be valid before the next rising edge.
- imemclk  output  1  instruction-memory read clock, equal to ~clock.
- dmemaddr  output  32  data address, rs1 + imm.
- dmemdataout  input  32  load data from data memory, right-aligned per dmemop.
- dmemdatain  output  32  store data, rs2 value.
- dmemrdclk  output  1  data read clock, equal to ~clock.
- dmemwrclk  output  1  data write clock, equal to clock; memory commits on its rising edge when dmemwe=1.
- dmemop  output  3  access size/sign, equal to funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dmemwe  output  1  store enable.
- dbgdata  output  32  debug word; see Optional Feature.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: on a rising edge with reset=1:
  - PC <= RESET_PC; x1..x31 <= 0.
  - While reset=1: dmemwe=0 and no register write occurs.
- x0 always reads 0; writes to x0 are discarded.
- Per cycle (combinational):
  - decode imemdataout; read rs1/rs2 asynchronously; generate I/S/B/U/J immediate (sign-extended); ALU computes.
- On the rising edge:
  - PC <= next PC.
  - rd <= writeback value if RegWrite=1 and rd != 0.
- Supported instructions and writeback:
  - LUI: rd = imm.
  - AUIPC: rd = PC + imm.
  - JAL: rd = PC+4; PC = PC + imm.
  - JALR: rd = PC+4; PC = (rs1 + imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: PC = taken ? PC + imm : PC + 4.
  - Loads LB/LH/LW/LBU/LHU: rd = dmemdataout.
  - Stores SB/SH/SW: dmemwe=1.
  - OP-IMM: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - OP: ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
  - Shift amount = low 5 bits.
- Arithmetic: all 32-bit, wraparound on overflow, no exceptions. SLT signed compare; SLTU unsigned compare.
- Default next PC is PC+4, wrapping at 2^32.
- FENCE, ECALL, EBREAK and unknown opcodes act as NOPs: PC+4, no register write, dmemwe=0.
- dmemaddr/dmemdatain/dmemop are don't-care when not load/store; drive dmemop=funct3 regardless.
- Self-modifying and load-after-store timing follow the external memory; the core adds no forwarding or stalls.

Optional Feature:
- Macro RV32IS_DBG_WB_EN.
- Defined: dbgdata = writeback value of the current instruction when RegWrite=1 and rd!=0, else 0.
- Undefined: dbgdata = current PC.
- Both variants: dbgdata = RESET_PC-derived value (PC or 0) during reset.

Decomposition:
- Shared package rv32is_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - ALU-op enum typedef;
  - immediate-type enum;
  - dmemop encodings.
- One natural sub-module: rv32is_alu, taking A, B and ALU op and producing result, zero and less-than flags.
- Register file and immediate generator stay inline.

Test Plan:
- Reset held 1 cycle, then released → imemaddr=0; PC advances 0,4,8 on successive edges; dmemwe=0 during reset.
- Sequence 06400313, 01400393, 00730e33 (addi x6=100; addi x7=20; add x28=x6+x7), then 00602023 and 00702023:
  - the two stores show dmemaddr=0, dmemop=010, dmemwe=1;
  - dmemdatain=100, then 20;
  - with RV32IS_DBG_WB_EN, dbgdata shows 100, 20, 120 on the three ALU cycles.
- addi x5,x0,-1; sltu x6,x0,x5; slt x7,x0,x5; srai x8,x5,4 → x6=1, x7=0, x8=FFFFFFFF.
- Branches:
  - beq x0,x0,+8 at PC 0x20 → next imemaddr 0x28;
  - bne x0,x0,+8 → 0x24;
  - blt -1,1 taken; bltu -1,1 not taken.
- jal x1,+16 at PC 0x40 → PC 0x50, x1=0x44; jalr x0,0(x1) → PC 0x44; lui x9,0x12345 → x9=12345000.
- Loads with dmemdataout=FFFFFF80 driven: lb → rd=FFFFFF80, dmemop=000; lbu variant with right-aligned 00000080 → rd=00000080; write to x0 leaves x0=0.

Source files
------------

// File: rtl/rv32is_pkg.sv
// Shared definitions for the rv32is single-cycle core: opcodes, ALU ops,
// immediate formats, writeback sources and data-memory access encodings.
package rv32is_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  // dmemop encodings (equal to funct3 of loads/stores)
  localparam logic [2:0] DmemB  = 3'b000;
  localparam logic [2:0] DmemH  = 3'b001;
  localparam logic [2:0] DmemW  = 3'b010;
  localparam logic [2:0] DmemBu = 3'b100;
  localparam logic [2:0] DmemHu = 3'b101;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} wb_sel_e;

  // Map funct3 plus the instr[30] "alternate" bit onto an ALU operation.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32is_alu.sv
// 32-bit integer ALU for the rv32is core. Flags are derived from the operands
// (lt/ltu) and the result (zero) so branches can use a subtract.
module rv32is_alu
  import rv32is_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt,
  output logic        ltu
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operand comparisons used by SLT/SLTU and by the branch unit
  always_comb begin
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
  end

  // Result select
  always_comb begin
    result = '0;
    case (op)
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluSll:   result = a << shamt;
      AluSlt:   result = {31'b0, lt};
      AluSltu:  result = {31'b0, ltu};
      AluXor:   result = a ^ b;
      AluSrl:   result = a >> shamt;
      AluSra:   result = $unsigned($signed(a) >>> shamt);
      AluOr:    result = a | b;
      AluAnd:   result = a & b;
      AluPassB: result = b;
      default:  result = a + b;
    endcase
  end

  assign zero = (result == 32'b0);

endmodule

// File: rtl/rv32is_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire in one clock.
// Optional macro RV32IS_DBG_WB_EN switches dbgdata from the current PC to the
// writeback value of the retiring instruction.
module rv32is_core
  import rv32is_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemdataout,
  output logic        imemclk,
  output logic [31:0] dmemaddr,
  input  logic [31:0] dmemdataout,
  output logic [31:0] dmemdatain,
  output logic        dmemrdclk,
  output logic        dmemwrclk,
  output logic [2:0]  dmemop,
  output logic        dmemwe,
  output logic [31:0] dbgdata
);

  logic [31:0] pc, pc_next, pc4, pc_imm;
  logic [31:0] regs [32];
  logic [31:0] instr, imm, rs1_val, rs2_val, alu_a, alu_b, alu_res, wb_val;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        reg_write, a_pc, b_imm, is_branch, is_jal, is_jalr, is_store, taken;
  logic        alu_zero, alu_lt, alu_ltu;
  alu_op_e     alu_op;
  imm_type_e   imm_type;
  wb_sel_e     wb_sel;

  assign instr  = imemdataout;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign rs1_val = (rs1 == 5'd0) ? 32'b0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'b0 : regs[rs2];

  // Main decoder; anything unrecognised (FENCE, SYSTEM, ...) is a NOP
  always_comb begin
    reg_write = 1'b0;
    a_pc      = 1'b0;
    b_imm     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_store  = 1'b0;
    alu_op    = AluAdd;
    imm_type  = ImmI;
    wb_sel    = WbAlu;
    case (opcode)
      OpcLui:    begin reg_write = 1'b1; imm_type = ImmU; b_imm = 1'b1; alu_op = AluPassB; end
      OpcAuipc:  begin reg_write = 1'b1; imm_type = ImmU; b_imm = 1'b1; a_pc = 1'b1; end
      OpcJal:    begin reg_write = 1'b1; imm_type = ImmJ; is_jal = 1'b1; wb_sel = WbPc4; end
      OpcJalr:   begin reg_write = 1'b1; b_imm = 1'b1; is_jalr = 1'b1; wb_sel = WbPc4; end
      OpcBranch: begin imm_type = ImmB; alu_op = AluSub; is_branch = 1'b1; end
      OpcLoad:   begin reg_write = 1'b1; b_imm = 1'b1; wb_sel = WbMem; end
      OpcStore:  begin imm_type = ImmS; b_imm = 1'b1; is_store = 1'b1; end
      OpcOpImm:  begin
        reg_write = 1'b1;
        b_imm     = 1'b1;
        // instr[30] is only an opcode bit for SRAI; elsewhere it is immediate data
        alu_op    = alu_decode(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OpcOp:     begin reg_write = 1'b1; alu_op = alu_decode(funct3, instr[30]); end
      default:   ;
    endcase
  end

  // Immediate generator, sign-extended from instr[31]
  always_comb begin
    imm = '0;
    case (imm_type)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'b0};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign alu_a = a_pc ? pc : rs1_val;
  assign alu_b = b_imm ? imm : rs2_val;

  rv32is_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  // Branch condition from the rs1 - rs2 flags
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;

  // Next-PC select
  always_comb begin
    pc_next = pc4;
    if (is_jal || (is_branch && taken)) begin
      pc_next = pc_imm;
    end else if (is_jalr) begin
      pc_next = alu_res & ~32'd1;
    end
  end

  // Writeback source select
  always_comb begin
    wb_val = alu_res;
    case (wb_sel)
      WbMem:   wb_val = dmemdataout;
      WbPc4:   wb_val = pc4;
      default: wb_val = alu_res;
    endcase
  end

  // PC register
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Register file; x0 is never written and reads are forced to zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_write && (rd != 5'd0)) begin
      regs[rd] <= wb_val;
    end
  end

  assign imemaddr   = pc;
  assign imemclk    = ~clock;
  assign dmemaddr   = alu_res;
  assign dmemdatain = rs2_val;
  assign dmemop     = funct3;
  assign dmemwe     = is_store && !reset;
  assign dmemrdclk  = ~clock;
  assign dmemwrclk  = clock;

`ifdef RV32IS_DBG_WB_EN
  assign dbgdata = (!reset && reg_write && (rd != 5'd0)) ? wb_val : 32'b0;
`else
  assign dbgdata = pc;
`endif

endmodule

// File: tb/tb_rv32is_core.sv
// Directed bench for rv32is_core: the bench plays instruction and data memory,
// feeding one hand-encoded instruction per cycle and checking the outputs.
module tb_rv32is_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imemaddr, imemdataout, dmemaddr, dmemdataout, dmemdatain, dbgdata;
  logic        imemclk, dmemrdclk, dmemwrclk, dmemwe;
  logic [2:0]  dmemop;

  int checks = 0;
  int errors = 0;

  rv32is_core #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imemaddr    (imemaddr),
    .imemdataout (imemdataout),
    .imemclk     (imemclk),
    .dmemaddr    (dmemaddr),
    .dmemdataout (dmemdataout),
    .dmemdatain  (dmemdatain),
    .dmemrdclk   (dmemrdclk),
    .dmemwrclk   (dmemwrclk),
    .dmemop      (dmemop),
    .dmemwe      (dmemwe),
    .dbgdata     (dbgdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // dbgdata carries the writeback value with the macro, the PC without it
  task automatic chk_dbg(input string tag, input logic [31:0] wb, input logic [31:0] pc);
`ifdef RV32IS_DBG_WB_EN
    chk(tag, dbgdata, wb);
`else
    chk(tag, dbgdata, pc);
`endif
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] dout);
    imemdataout = ins;
    dmemdataout = dout;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step(32'h0000_2023, 32'h0);             // sw x0,0(x0) held during reset
    chk("we_in_reset_pre", {31'b0, dmemwe}, 32'd0);
    tick();
    chk("reset_pc", imemaddr, 32'h0);
    chk("we_in_reset", {31'b0, dmemwe}, 32'd0);
    chk_dbg("dbg_in_reset", 32'h0, 32'h0);
    reset = 1'b0;

    step(32'h0000_0013, 32'h0);             // nop @0
    chk("pc0", imemaddr, 32'h0);
    chk("imemclk", {31'b0, imemclk}, 32'd0);
    chk("dmemwrclk", {31'b0, dmemwrclk}, 32'd1);
    tick();
    step(32'h0000_0013, 32'h0);             // nop @4
    chk("pc4", imemaddr, 32'h4);
    tick();
    step(32'h0640_0313, 32'h0);             // addi x6,x0,100 @8
    chk("pc8", imemaddr, 32'h8);
    chk_dbg("dbg_addi100", 32'd100, 32'h8);
    tick();
    step(32'h0140_0393, 32'h0);             // addi x7,x0,20 @C
    chk_dbg("dbg_addi20", 32'd20, 32'hC);
    tick();
    step(32'h0073_0e33, 32'h0);             // add x28,x6,x7 @10
    chk_dbg("dbg_add", 32'd120, 32'h10);
    tick();
    step(32'h0060_2023, 32'h0);             // sw x6,0(x0) @14
    chk("sw1_addr", dmemaddr, 32'h0);
    chk("sw1_op", {29'b0, dmemop}, 32'd2);
    chk("sw1_we", {31'b0, dmemwe}, 32'd1);
    chk("sw1_data", dmemdatain, 32'd100);
    tick();
    step(32'h0070_2023, 32'h0);             // sw x7,0(x0) @18
    chk("sw2_data", dmemdatain, 32'd20);
    chk("sw2_we", {31'b0, dmemwe}, 32'd1);
    tick();
    step(32'h01C0_2023, 32'h0);             // sw x28,0(x0) @1C
    chk("sw_x28", dmemdatain, 32'd120);
    tick();

    step(32'h0000_0463, 32'h0);             // beq x0,x0,+8 @20
    chk("pc20", imemaddr, 32'h20);
    chk("beq_no_we", {31'b0, dmemwe}, 32'd0);
    tick();
    chk("beq_taken", imemaddr, 32'h28);
    step(32'h0000_1463, 32'h0);             // bne x0,x0,+8 @28
    tick();
    chk("bne_not_taken", imemaddr, 32'h2C);

    step(32'hFFF0_0293, 32'h0);             // addi x5,x0,-1 @2C
    chk_dbg("dbg_m1", 32'hFFFF_FFFF, 32'h2C);
    tick();
    step(32'h0050_3333, 32'h0);             // sltu x6,x0,x5 @30
    chk_dbg("dbg_sltu", 32'd1, 32'h30);
    tick();
    step(32'h0050_23B3, 32'h0);             // slt x7,x0,x5 @34
    tick();
    step(32'h4042_D413, 32'h0);             // srai x8,x5,4 @38
    chk_dbg("dbg_srai", 32'hFFFF_FFFF, 32'h38);
    tick();
    step(32'h0060_2023, 32'h0);             // sw x6 @3C
    chk("sltu_res", dmemdatain, 32'd1);
    tick();
    step(32'h0070_2023, 32'h0);             // sw x7 @40
    chk("slt_res", dmemdatain, 32'd0);
    tick();
    step(32'h0080_2023, 32'h0);             // sw x8 @44
    chk("srai_res", dmemdatain, 32'hFFFF_FFFF);
    tick();
    step(32'h0062_A423, 32'h0);             // sw x6,8(x5) @48
    chk("sw_off_addr", dmemaddr, 32'h7);
    chk("sw_off_data", dmemdatain, 32'd1);
    tick();

    step(32'h0062_C463, 32'h0);             // blt x5,x6,+8 @4C
    tick();
    chk("blt_taken", imemaddr, 32'h54);
    step(32'h0062_E463, 32'h0);             // bltu x5,x6,+8 @54
    tick();
    chk("bltu_not_taken", imemaddr, 32'h58);

    step(32'h0100_00EF, 32'h0);             // jal x1,+16 @58
    chk_dbg("dbg_jal", 32'h5C, 32'h58);
    tick();
    chk("jal_target", imemaddr, 32'h68);
    step(32'h0000_8067, 32'h0);             // jalr x0,0(x1) @68
    chk_dbg("dbg_jalr_x0", 32'h0, 32'h68);
    tick();
    chk("jalr_target", imemaddr, 32'h5C);
    step(32'h0010_8067, 32'h0);             // jalr x0,1(x1) @5C, bit 0 cleared
    tick();
    chk("jalr_lsb_clear", imemaddr, 32'h5C);
    step(32'h1234_54B7, 32'h0);             // lui x9,0x12345 @5C
    chk_dbg("dbg_lui", 32'h1234_5000, 32'h5C);
    tick();
    step(32'h0090_2023, 32'h0);             // sw x9 @60
    chk("lui_res", dmemdatain, 32'h1234_5000);
    tick();
    step(32'h0000_1517, 32'h0);             // auipc x10,1 @64
    tick();
    step(32'h00A0_2023, 32'h0);             // sw x10 @68
    chk("auipc_res", dmemdatain, 32'h0000_1064);
    tick();

    step(32'h0000_0583, 32'hFFFF_FF80);     // lb x11,0(x0) @6C
    chk("lb_op", {29'b0, dmemop}, 32'd0);
    chk("lb_we", {31'b0, dmemwe}, 32'd0);
    chk_dbg("dbg_lb", 32'hFFFF_FF80, 32'h6C);
    tick();
    step(32'h00B0_2023, 32'h0);             // sw x11 @70
    chk("lb_res", dmemdatain, 32'hFFFF_FF80);
    tick();
    step(32'h0000_4603, 32'h0000_0080);     // lbu x12,0(x0) @74
    chk("lbu_op", {29'b0, dmemop}, 32'd4);
    tick();
    step(32'h00C0_2023, 32'h0);             // sw x12 @78
    chk("lbu_res", dmemdatain, 32'h0000_0080);
    tick();
    step(32'h0000_2003, 32'hDEAD_BEEF);     // lw x0,0(x0) @7C
    chk_dbg("dbg_lw_x0", 32'h0, 32'h7C);
    tick();
    step(32'h0000_2023, 32'h0);             // sw x0 @80
    chk("x0_zero", dmemdatain, 32'h0);
    tick();
    step(32'h4053_06B3, 32'h0);             // sub x13,x6,x5 @84
    chk_dbg("dbg_sub", 32'd2, 32'h84);
    tick();
    step(32'h00D0_2023, 32'h0);             // sw x13 @88
    chk("sub_res", dmemdatain, 32'd2);
    tick();
    step(32'h0000_0073, 32'h0);             // ecall @8C acts as NOP
    chk("ecall_we", {31'b0, dmemwe}, 32'd0);
    chk_dbg("dbg_ecall", 32'h0, 32'h8C);
    tick();
    chk("ecall_pc", imemaddr, 32'h90);

    reset = 1'b1;
    step(32'h0060_2023, 32'h0);             // store presented under reset
    chk("we_mid_reset", {31'b0, dmemwe}, 32'd0);
    tick();
    chk("pc_after_reset", imemaddr, 32'h0);
    reset = 1'b0;
    step(32'h0060_2023, 32'h0);             // sw x6: cleared by reset
    chk("regs_cleared", dmemdatain, 32'h0);
    tick();
    chk("pc_after_reset_adv", imemaddr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
